// File: rtl/acorn_ad_absorb.sv
// acorn_ad_absorb: ACORN-128 associated-data absorption stage.
// Takes the post-initialization state, absorbs ad_len bytes of AD bit-serially (LSB first,
// one state_update128 step per clock, ca=1/cb=1), then runs the 256-step padding phase.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start_i    one-cycle start request, sampled only when idle
//   state_in   293-bit post-initialization state
//   ad_len     AD length in bytes
//   ad_data    AD byte, ad_valid qualifies it, ad_ready accepts it
//   state_out  internal state register
//   busy       high from start acceptance until done
//   done       one-cycle completion pulse; state_out is final until the next start
//
// state_update128: one combinational ACORN-128 StateUpdate128 step.
//   rst forces the output to zero; ca_in/cb_in/mbit_in are the step control bits.

module state_update128 (
  input  logic         rst,
  input  logic [292:0] state_in,
  input  logic         ca_in,
  input  logic         cb_in,
  input  logic         mbit_in,
  output logic [292:0] state_out
);

  logic [292:0] s;
  logic         ks;
  logic         f;

  always_comb begin
    s = state_in;
    // LFSR feedback taps; every tap reads a not-yet-updated position
    s[289] = state_in[289] ^ state_in[235] ^ state_in[230];
    s[230] = state_in[230] ^ state_in[196] ^ state_in[193];
    s[193] = state_in[193] ^ state_in[160] ^ state_in[154];
    s[154] = state_in[154] ^ state_in[111] ^ state_in[107];
    s[107] = state_in[107] ^ state_in[66]  ^ state_in[61];
    s[61]  = state_in[61]  ^ state_in[23]  ^ state_in[0];

    // keystream bit uses the updated taps
    ks = s[12] ^ s[154]
       ^ ((s[235] & s[61]) ^ (s[235] & s[193]) ^ (s[61] & s[193]))
       ^ ((s[230] & s[111]) ^ (~s[230] & s[66]));

    f = s[0] ^ ~s[107]
      ^ ((s[244] & s[23]) ^ (s[244] & s[160]) ^ (s[23] & s[160]))
      ^ (ca_in & s[196]) ^ (cb_in & ks) ^ mbit_in;

    state_out = rst ? '0 : {f, s[292:1]};
  end

endmodule

module acorn_ad_absorb #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned PAD_STEPS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [292:0]     state_in,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [7:0]       ad_data,
  input  logic             ad_valid,
  output logic             ad_ready,
  output logic [292:0]     state_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {StIdle, StAdWait, StAdShift, StPad, StDone} state_e;

  localparam logic [8:0] PadLast = 9'(PAD_STEPS - 1);
  localparam logic [8:0] PadHalf = 9'(PAD_STEPS / 2);

  state_e           st_q;
  logic [292:0]     state_q;
  logic [292:0]     sup128_out;
  logic [LEN_W-1:0] byte_cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [8:0]       pad_cnt_q;
  logic [7:0]       byte_buf_q;
  logic             busy_q;
  logic             done_q;

  logic step;
  logic mbit;
  logic ca;
  logic cb;

  state_update128 u_sup128 (
    .rst      (~rst),
    .state_in (state_q),
    .ca_in    (ca),
    .cb_in    (cb),
    .mbit_in  (mbit),
    .state_out(sup128_out)
  );

  // Step control: AD bits with ca=cb=1; padding injects a single 1 and drops ca halfway.
  always_comb begin
    step = 1'b0;
    mbit = 1'b0;
    ca   = 1'b0;
    cb   = 1'b0;
    case (st_q)
      StAdShift: begin
        step = 1'b1;
        mbit = byte_buf_q[bit_cnt_q];
        ca   = 1'b1;
        cb   = 1'b1;
      end
      StPad: begin
        step = 1'b1;
        mbit = (pad_cnt_q == 9'd0);
        ca   = (pad_cnt_q < PadHalf);
        cb   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= StIdle;
      state_q    <= '0;
      byte_cnt_q <= '0;
      bit_cnt_q  <= '0;
      pad_cnt_q  <= '0;
      byte_buf_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      if (step) begin
        state_q <= sup128_out;
      end
      case (st_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= state_in;
            byte_cnt_q <= ad_len;
            busy_q     <= 1'b1;
            pad_cnt_q  <= '0;
            st_q       <= (ad_len != '0) ? StAdWait : StPad;
          end
        end
        StAdWait: begin
          if (ad_valid) begin
            byte_buf_q <= ad_data;
            bit_cnt_q  <= '0;
            byte_cnt_q <= byte_cnt_q - 1'b1;
            st_q       <= StAdShift;
          end
        end
        StAdShift: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            pad_cnt_q <= '0;
            st_q      <= (byte_cnt_q != '0) ? StAdWait : StPad;
          end
        end
        StPad: begin
          pad_cnt_q <= pad_cnt_q + 1'b1;
          if (pad_cnt_q == PadLast) begin
            done_q <= 1'b1;
            st_q   <= StDone;
          end
        end
        StDone: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          st_q   <= StIdle;
        end
        default: st_q <= StIdle;
      endcase
    end
  end

  assign ad_ready  = (st_q == StAdWait);
  assign state_out = state_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
